// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer: plays a small programmed a/b stimulus sequence into an
// example FSM and counts the steps where its Mealy (x_in) / Moore (y_in) outputs are nonzero.
// Ports: clk, rst_n (sync, active-low); cfg_we/cfg_addr/cfg_ab program-memory writes;
//        cfg_len/start/abort run control; a, b stimulus; x_in, y_in FSM outputs;
//        busy, done status; x_hits, y_hits step counters.
module fsm_stim_sequencer #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [1:0]    cfg_ab,
    input  logic [AW:0]   cfg_len,
    input  logic          start,
    input  logic          abort,
    output logic          a,
    output logic          b,
    input  logic [7:0]    x_in,
    input  logic [7:0]    y_in,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   x_hits,
    output logic [AW:0]   y_hits
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    mem [DEPTH];
    logic [AW:0]   len;
    logic [AW-1:0] idx;

    logic          x_hit;
    logic          y_hit;
    logic          last_step;
    logic [AW-1:0] idx_nxt;
    logic [AW:0]   x_inc;
    logic [AW:0]   y_inc;

    assign x_hit     = |x_in;
    assign y_hit     = |y_in;
    assign x_inc     = {{AW{1'b0}}, x_hit};
    assign y_inc     = {{AW{1'b0}}, y_hit};
    assign idx_nxt   = idx + 1'b1;
    // len is never zero in RUN, so len-1 cannot wrap
    assign last_step = ({1'b0, idx} == (len - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            len    <= '0;
            idx    <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x_hits <= '0;
            y_hits <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        mem[cfg_addr] <= cfg_ab;
                    end
                    // start takes priority over abort here; abort is a no-op in IDLE
                    if (start) begin
                        x_hits <= '0;
                        y_hits <= '0;
                        idx    <= '0;
                        if (cfg_len != '0) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            len    <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                            {a, b} <= mem[0];
                        end else begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            {a, b} <= 2'b00;
                        end
                    end
                end
                S_RUN: begin
                    // the step driven this cycle is sampled on every RUN edge,
                    // including the abort edge
                    x_hits <= x_hits + x_inc;
                    y_hits <= y_hits + y_inc;
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        {a, b} <= 2'b00;
                    end else if (last_step) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        {a, b} <= 2'b00;
                    end else begin
                        idx    <= idx_nxt;
                        {a, b} <= mem[idx_nxt];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    {a, b} <= 2'b00;
                end
            endcase
        end
    end

endmodule
